// File: rtl/pc_fetch_gen_pkg.sv
// Purpose: shared widths, reset PC, instruction stride and fetch FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_gen_pkg;

    localparam int unsigned          CPU_WIDTH       = 32;
    localparam logic [CPU_WIDTH-1:0] RESET_PC_DFLT   = 32'h8000_0000;
    localparam int unsigned          INST_BYTES_DFLT = 4;
    localparam int unsigned          INST_W_DFLT     = 32;

    // One fetch in flight at a time: issue, wait for the response, hold it for decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_redir_mux.sv
// Purpose: pick the redirect target (trap beats branch) and force instruction alignment.
// Latency: purely combinational.
// Backpressure: none; redirects are never refused.
module pc_redir_mux
    import pc_fetch_gen_pkg::*;
#(
    parameter int unsigned XLEN       = CPU_WIDTH,
    parameter int unsigned INST_BYTES = INST_BYTES_DFLT
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    output logic            redir,
    output logic [XLEN-1:0] tgt
);

    // A stride of 1 byte needs no alignment; otherwise clear the sub-instruction bits.
    localparam int unsigned     ALIGN_BITS = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 0;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

    // Trap/mret redirects win; a branch in the same cycle is simply dropped.
    always_comb begin
        redir = trap_valid | br_valid;
        tgt   = (trap_valid ? trap_pc : br_pc) & ALIGN_MASK;
    end

endmodule

// File: rtl/pc_fetch_gen.sv
// Purpose: fetch PC register and single-outstanding fetch request generator with a one-entry decode buffer.
// Latency: request accept -> response -> out_valid the cycle after rsp_valid; 3 cycles per instruction best case.
// Backpressure: stall/req_ready hold issue, out_ready holds the buffer; redirects and responses are never blocked.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int unsigned     XLEN       = CPU_WIDTH,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DFLT),
    parameter int unsigned     INST_BYTES = INST_BYTES_DFLT,
    parameter int unsigned     INST_W     = INST_W_DFLT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              redir_trap_valid,
    input  logic [XLEN-1:0]   redir_trap_pc,
    input  logic              redir_br_valid,
    input  logic [XLEN-1:0]   redir_br_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_pc,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_inst,
    input  logic              rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_fault
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(INST_BYTES);

    logic            redir;
    logic [XLEN-1:0] tgt;

    pc_redir_mux #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES)
    ) u_redir_mux (
        .trap_valid (redir_trap_valid),
        .trap_pc    (redir_trap_pc),
        .br_valid   (redir_br_valid),
        .br_pc      (redir_br_pc),
        .redir      (redir),
        .tgt        (tgt)
    );

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   issued_pc_q, issued_pc_d;
    logic              kill_q, kill_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              req_hs;

    assign req_hs = (state_q == REQ) && !stall && req_ready;

    // Next-state logic: a redirect always retargets pc, whatever the state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        kill_d      = kill_q;
        inst_d      = inst_q;
        fault_d     = fault_q;
        out_pc_d    = out_pc_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redir) pc_d = tgt;
            end
            REQ: begin
                if (req_hs) begin
                    issued_pc_d = pc_q;
                    pc_d        = redir ? tgt : pc_q + PC_INC;
                    // A redirect in the accept cycle makes the just-issued fetch wrong-path.
                    kill_d      = redir;
                    state_d     = WAIT;
                end else if (redir) begin
                    pc_d = tgt;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (kill_q || redir) begin
                        kill_d  = 1'b0;
                        if (redir) pc_d = tgt;
                        state_d = REQ;
                    end else begin
                        inst_d   = rsp_inst;
                        fault_d  = rsp_err;
                        out_pc_d = issued_pc_q;
                        state_d  = OUT;
                    end
                end else if (redir) begin
                    pc_d   = tgt;
                    kill_d = 1'b1;
                end
            end
            OUT: begin
                if (redir) begin
                    pc_d    = tgt;
                    inst_d  = '0;
                    fault_d = 1'b0;
                    state_d = REQ;
                end else if (out_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and buffer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            kill_q      <= 1'b0;
            inst_q      <= '0;
            fault_q     <= 1'b0;
            out_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            kill_q      <= kill_d;
            inst_q      <= inst_d;
            fault_q     <= fault_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // out_valid is masked the same cycle a redirect arrives: the buffered
    // instruction is younger than whatever caused the redirect.
    always_comb begin
        req_valid = (state_q == REQ) && !stall;
        req_pc    = pc_q;
        out_valid = (state_q == OUT) && !redir;
        out_pc    = out_pc_q;
        out_inst  = inst_q;
        out_fault = fault_q;
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Purpose: self-checking bench for pc_fetch_gen (vector table, directed corner cases, random vs. transaction model).
// Latency: n/a.
// Backpressure: bench randomises stall, req_ready and out_ready.
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall, redir_trap_valid, redir_br_valid;
    logic [31:0] redir_trap_pc, redir_br_pc;
    logic        req_valid, req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_inst;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_pc, out_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_gen dut (
        .clk              (clk),
        .rstn             (rstn),
        .stall            (stall),
        .redir_trap_valid (redir_trap_valid),
        .redir_trap_pc    (redir_trap_pc),
        .redir_br_valid   (redir_br_valid),
        .redir_br_pc      (redir_br_pc),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_pc           (req_pc),
        .rsp_valid        (rsp_valid),
        .rsp_inst         (rsp_inst),
        .rsp_err          (rsp_err),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_inst         (out_inst),
        .out_fault        (out_fault)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall            = 1'b0;
        redir_trap_valid = 1'b0;
        redir_trap_pc    = '0;
        redir_br_valid   = 1'b0;
        redir_br_pc      = '0;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_inst         = '0;
        rsp_err          = 1'b0;
        out_ready        = 1'b0;
    endtask

    // Reset is asserted at a falling edge and released at a falling edge.
    task automatic do_reset(input string nm);
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        #1;
        chk({nm, "_req_valid"}, req_valid, 0);
        chk({nm, "_req_pc"},    req_pc,    32'h8000_0000);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_pc"},    out_pc,    32'h8000_0000);
        chk({nm, "_out_inst"},  out_inst,  0);
        chk({nm, "_out_fault"}, out_fault, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Called just after a falling edge; returns at negedge+1 with req_valid seen (or budget expired).
    task automatic wait_req(input string nm, input logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (req_valid) found = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_req_seen"}, found, 1);
        if (found) chk({nm, "_req_pc"}, req_pc, exp_pc);
    endtask

    // One full fetch with req_ready=1: request, response next cycle, check buffer contents.
    task automatic fetch_one(input string nm, input logic [31:0] exp_pc,
                             input logic [31:0] inst, input logic err);
        wait_req(nm, exp_pc);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_inst  = inst;
        rsp_err   = err;
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_out_pc"},    out_pc,    exp_pc);
        chk({nm, "_out_inst"},  out_inst,  inst);
        chk({nm, "_out_fault"}, out_fault, err);
    endtask

    typedef struct {
        logic        tv;
        logic [31:0] tpc;
        logic        bv;
        logic [31:0] bpc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] pick_tgt();
        case ($urandom % 3)
            0:       return 32'h8000_0000 + ($urandom % 64) * 4 + ($urandom % 4);
            1:       return 32'hFFFF_FFF0 + ($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    // Transaction-level reference state for the random phase.
    logic [31:0] m_pc, m_opc, b_pc, b_inst, m_tgt;
    bit          m_out, m_kill, m_buf, b_err, m_redir, hs, want_live;
    int          m_cnt;

    initial begin
        idle_inputs();

        // Redirect priority/alignment table, applied while stalled so no request issues.
        vecs[0] = '{1'b1, 32'h8000_0100, 1'b1, 32'h8000_2000, 32'h8000_0100};
        vecs[1] = '{1'b0, 32'h1111_1111, 1'b1, 32'h8000_3002, 32'h8000_3000};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0040, 32'hFFFF_FFFC};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hFFFF_FFFC};
        vecs[4] = '{1'b1, 32'h1234_5677, 1'b0, 32'h8000_0000, 32'h1234_5674};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'h0000_0000};

        do_reset("rst0");
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            redir_trap_valid = vecs[i].tv;
            redir_trap_pc    = vecs[i].tpc;
            redir_br_valid   = vecs[i].bv;
            redir_br_pc      = vecs[i].bpc;
            @(negedge clk);
            redir_trap_valid = 1'b0;
            redir_br_valid   = 1'b0;
            #1;
            chk($sformatf("tbl%0d_req_pc", i), req_pc, vecs[i].exp_pc);
            chk($sformatf("tbl%0d_req_valid", i), req_valid, 0);
        end

        // Straight-line fetch of three instructions.
        do_reset("rst1");
        req_ready = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            fetch_one($sformatf("seq%0d", i), 32'h8000_0000 + 32'(i) * 4, 32'(i), 1'b0);

        // Branch redirect while waiting: the response is wrong-path.
        wait_req("wkill_a", 32'h8000_000C);
        @(negedge clk);
        redir_br_valid = 1'b1;
        redir_br_pc    = 32'h8000_1000;
        @(negedge clk);
        redir_br_valid = 1'b0;
        rsp_valid      = 1'b1;
        rsp_inst       = 32'hDEAD_BEEF;
        req_ready      = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("wkill_out_valid", out_valid, 0);
        @(negedge clk);
        wait_req("wkill_b", 32'h8000_1000);

        // Stall for five cycles with a misaligned redirect in the middle.
        stall = 1'b1;
        #1;
        chk("stall0_req_valid", req_valid, 0);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            redir_br_valid = (k == 2);
            redir_br_pc    = 32'h8000_3002;
            #1;
            chk($sformatf("stall%0d_req_valid", k), req_valid, 0);
        end
        @(negedge clk);
        redir_br_valid = 1'b0;
        stall          = 1'b0;
        req_ready      = 1'b1;
        wait_req("stall_rel", 32'h8000_3000);

        // Decode holds the buffer, then a redirect kills it.
        out_ready = 1'b0;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_inst  = 32'h5555_AAAA;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
            chk($sformatf("hold%0d_out_pc", k),    out_pc,    32'h8000_3000);
            chk($sformatf("hold%0d_out_inst", k),  out_inst,  32'h5555_AAAA);
            chk($sformatf("hold%0d_req_valid", k), req_valid, 0);
            @(negedge clk);
        end
        redir_br_valid = 1'b1;
        redir_br_pc    = 32'h8000_4000;
        #1;
        chk("holdkill_same_cycle", out_valid, 0);
        @(negedge clk);
        redir_br_valid = 1'b0;
        #1;
        chk("holdkill_after", out_valid, 0);
        chk("holdkill_req_pc", req_pc, 32'h8000_4000);

        // Access fault propagation, then reset during WAIT with a late response.
        req_ready = 1'b1;
        out_ready = 1'b1;
        fetch_one("fault", 32'h8000_4000, 32'h0000_1234, 1'b1);
        rsp_err = 1'b0;
        wait_req("rstwait", 32'h8000_4004);
        @(negedge clk);
        req_ready = 1'b0;
        rstn      = 1'b0;
        #1;
        chk("rstwait_req_pc",    req_pc,    32'h8000_0000);
        chk("rstwait_req_valid", req_valid, 0);
        chk("rstwait_out_pc",    out_pc,    32'h8000_0000);
        @(negedge clk);
        rstn      = 1'b1;
        rsp_valid = 1'b1;
        rsp_inst  = 32'hBAD0_BAD0;
        #1;
        chk("late_rsp_idle_req_valid", req_valid, 0);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("late_rsp_out_valid", out_valid, 0);
        wait_req("late_rsp", 32'h8000_0000);

        // Random traffic against the transaction model.
        do_reset("rst2");
        m_pc   = 32'h8000_0000;
        m_out  = 1'b0;
        m_kill = 1'b0;
        m_buf  = 1'b0;
        m_cnt  = 0;
        m_opc  = '0;
        b_pc   = '0;
        b_inst = '0;
        b_err  = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            stall            = ($urandom % 4 == 0);
            req_ready        = ($urandom % 3 != 0);
            out_ready        = ($urandom % 3 != 0);
            redir_trap_valid = ($urandom % 25 == 0);
            redir_br_valid   = ($urandom % 12 == 0);
            redir_trap_pc    = pick_tgt();
            redir_br_pc      = pick_tgt();
            if (m_out && m_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_inst  = $urandom;
                rsp_err   = ($urandom % 6 == 0);
            end else begin
                rsp_valid = (!m_out && ($urandom % 8 == 0));
                rsp_inst  = $urandom;
                rsp_err   = $urandom % 2;
            end
            #1;

            m_redir = redir_trap_valid | redir_br_valid;
            m_tgt   = redir_trap_valid ? redir_trap_pc : redir_br_pc;
            m_tgt   = {m_tgt[31:2], 2'b00};
            hs      = req_valid & req_ready;

            if (stall) chk("rnd_stall_noreq", req_valid, 0);
            if (req_valid) chk("rnd_one_in_flight", {m_out, m_buf}, 0);
            want_live = !m_out && !m_buf && !stall && (cyc > 0);
            if (want_live) chk("rnd_req_live", req_valid, 1);
            if (hs) chk("rnd_req_pc", req_pc, m_pc);
            if (m_buf) begin
                chk("rnd_out_valid", out_valid, !m_redir);
                chk("rnd_out_pc",    out_pc,    b_pc);
                chk("rnd_out_inst",  out_inst,  b_inst);
                chk("rnd_out_fault", out_fault, b_err);
            end else begin
                chk("rnd_out_idle", out_valid, 0);
            end

            if (m_buf && (m_redir || out_ready)) m_buf = 1'b0;
            if (m_out) begin
                if (rsp_valid) begin
                    if (!m_kill && !m_redir) begin
                        m_buf  = 1'b1;
                        b_pc   = m_opc;
                        b_inst = rsp_inst;
                        b_err  = rsp_err;
                    end
                    m_out = 1'b0;
                end else begin
                    if (m_redir) m_kill = 1'b1;
                    m_cnt--;
                end
            end
            if (hs) begin
                m_out  = 1'b1;
                m_kill = m_redir;
                m_opc  = m_pc;
                m_cnt  = $urandom % 3;
            end
            m_pc = m_redir ? m_tgt : (hs ? m_pc + 32'd4 : m_pc);

            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
Parametrised program-counter and fetch-request generator, successor to the single always-enabled PC register.
- Holds the architectural fetch PC and issues one fetch request at a time over a valid/ready request channel.
- Accepts trap and branch redirects at any time, kills wrong-path responses, and buffers one fetched instruction toward decode.
- Sits at the head of the IFU, between the redirect sources (EXU/CSR) and the instruction memory port.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h80000000, PC value loaded on reset
INST_BYTES, 4, sequential PC increment; low log2(INST_BYTES) bits of redirect targets are forced to 0
INST_W, 32, fetched instruction width

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
stall  in  1  1 = do not issue new fetch requests
redir_trap_valid  in  1  trap/mret redirect, highest priority
redir_trap_pc  in  XLEN  trap redirect target
redir_br_valid  in  1  branch/jump redirect
redir_br_pc  in  XLEN  branch redirect target
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts request
req_pc  out  XLEN  fetch address
rsp_valid  in  1  fetch response valid (one per accepted request)
rsp_inst  in  INST_W  fetched instruction
rsp_err  in  1  access fault on this fetch
out_valid  out  1  instruction to decode valid
out_ready  in  1  decode accepts instruction
out_pc  out  XLEN  PC of delivered instruction
out_inst  out  INST_W  delivered instruction
out_fault  out  1  delivered instruction carries access fault

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, pc=RESET_PC, issued_pc=RESET_PC, kill=0, inst buffer=0.
  - All outputs read 0, except req_pc and out_pc, which read RESET_PC.
- redir = redir_trap_valid | redir_br_valid.
  - tgt = trap target if redir_trap_valid, else branch target.
  - Low bits of tgt are cleared per INST_BYTES.
- States:
  - IDLE: req_valid=0. Next cycle go to REQ unconditionally. A redirect seen in IDLE still loads pc.
  - REQ:
    - req_valid = !stall; req_pc = pc. req_pc may change before acceptance; memory samples only on handshake.
    - Handshake (req_valid&req_ready): issued_pc<=pc; pc <= redir ? tgt : pc+INST_BYTES; kill<=redir; go to WAIT.
    - No handshake: pc <= redir ? tgt : pc; stay in REQ.
  - WAIT:
    - req_valid=0.
    - redir without rsp_valid: pc<=tgt, kill<=1.
    - rsp_valid with (kill|redir): discard the response; kill<=0; pc<=tgt if redir; go to REQ.
    - rsp_valid otherwise: capture rsp_inst/rsp_err, out_pc<=issued_pc; go to OUT.
  - OUT:
    - out_valid = !redir (combinational mask; a younger instruction is killed by any redirect).
    - redir: drop the buffer, pc<=tgt, go to REQ.
    - out_ready & !redir: go to REQ.
    - Otherwise hold all out_* stable.
- PC arithmetic is modulo 2^XLEN; 32'hFFFFFFFC+4 wraps to 0.
- Simultaneous trap and branch: trap wins; branch is ignored.
- rsp_valid in IDLE/REQ/OUT: ignored. This covers a stale response after reset.
- Fetch latency: request-accept to out_valid is ≥1 cycle after rsp_valid (registered output). Best-case loop REQ→WAIT→OUT→REQ is 3 cycles per instruction.
- stall affects only request issue. It never blocks redirects or responses.

Decomposition:
- Shared package/defines: XLEN (CPU_WIDTH), RESET_PC value, INST_BYTES, state encoding constants IDLE/REQ/WAIT/OUT.
- One natural sub-module: pc_redir_mux, the combinational priority select plus alignment of the redirect target.
- The PC and buffer registers reuse the team's enabled register template with reset value.

Test Plan:
1. Reset release with req_ready=1, rsp_valid 1 cycle after each accept with inst=i, out_ready=1 → req_pc sequence 80000000, 80000004, 80000008; out_pc matches and out_inst in order.
2. In WAIT, assert redir_br_valid with pc=80001000 → next response is discarded (out_valid stays 0); next req_pc=80001000.
3. Same cycle: redir_trap_pc=80000100 and redir_br_pc=80002000 → req_pc=80000100.
4. stall=1 in REQ for 5 cycles, redirect to 80003002 during the stall → req_valid=0 throughout; after release req_pc=80003000.
5. OUT with out_ready=0 for 4 cycles → out_* stable, no new request; then redir → out_valid drops the same cycle and the buffered instruction is never delivered.
6. rsp_err=1 → out_fault=1 with the correct out_pc. Assert rstn low during WAIT, then a late rsp_valid → state IDLE, req_pc=80000000, late response ignored.
